// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc: registered EX-stage ALU with ALUOp/Funct decode, logical shifts,
// HI/LO registers and an iterative shift-add multiplier (signed/unsigned).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   an operation is presented this cycle
//   ALUOp      00 add, 01 sub, 10 decode Funct, 11 reserved (illegal)
//   Funct      R-type function field
//   Shamt      shift amount
//   A, B       operands (rs, rt/immediate)
//   result     registered result
//   zero       registered (result == 0)
//   out_valid  one-cycle pulse qualifying result/zero/illegal
//   illegal    undecodable operation, qualified by out_valid
//   busy       cannot accept an operation (stall request)
//   hi, lo     HI/LO product registers
// ---------------------------------------------------------------------------
module alu_mc #(
    parameter int WIDTH  = 32,
    parameter int SHW    = 5,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       Funct,
    input  logic [SHW-1:0]   Shamt,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             out_valid,
    output logic             illegal,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_SLL, OP_SRL,
        OP_MFHI, OP_MFLO, OP_MULT, OP_MULTU, OP_ILL
    } op_t;

    localparam bit HAS_MUL = (MUL_EN != 0);

    state_t               state;
    op_t                  op;
    logic [WIDTH-1:0]     alu_res;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;

    // Multiplier datapath: mcand is the magnitude of the multiplicand; prod
    // holds {partial sum, remaining multiplier bits} and shifts right each step.
    logic [WIDTH-1:0]     mcand;
    logic [2*WIDTH-1:0]   prod;
    logic                 neg;
    logic [SHW-1:0]       cnt;
    logic [WIDTH:0]       step_sum;
    logic [2*WIDTH-1:0]   prod_step;
    logic [2*WIDTH-1:0]   prod_final;

    logic                 accept;
    logic                 is_mul;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;

    assign accept = in_valid && !busy;
    assign is_mul = (op == OP_MULT) || (op == OP_MULTU);

    // Without the multiplier the HI/LO registers never load, so tie them off.
    assign hi = HAS_MUL ? hi_q : '0;
    assign lo = HAS_MUL ? lo_q : '0;

    // ---------------------------------------------------------------------
    // Decode
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // through the case statements can leave it unassigned (latch).
        op = OP_ILL;
        case (ALUOp)
            2'b00: op = OP_ADD;
            2'b01: op = OP_SUB;
            2'b10: begin
                case (Funct)
                    6'd32: op = OP_ADD;
                    6'd34: op = OP_SUB;
                    6'd36: op = OP_AND;
                    6'd37: op = OP_OR;
                    6'd42: op = OP_SLT;
                    6'd0:  op = OP_SLL;
                    6'd2:  op = OP_SRL;
                    6'd16: op = HAS_MUL ? OP_MFHI  : OP_ILL;
                    6'd18: op = HAS_MUL ? OP_MFLO  : OP_ILL;
                    6'd24: op = HAS_MUL ? OP_MULT  : OP_ILL;
                    6'd25: op = HAS_MUL ? OP_MULTU : OP_ILL;
                    default: op = OP_ILL;
                endcase
            end
            default: op = OP_ILL;
        endcase
    end

    // ---------------------------------------------------------------------
    // Single-cycle datapath (illegal and multiply ops yield 0 here)
    // ---------------------------------------------------------------------
    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = A + B;
            OP_SUB:  alu_res = A - B;
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_SLT:  alu_res = ($signed(A) < $signed(B)) ? WIDTH'(1) : '0;
            OP_SLL:  alu_res = B << Shamt;
            OP_SRL:  alu_res = B >> Shamt;
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    // ---------------------------------------------------------------------
    // Multiplier step: add the multiplicand into the upper half when the
    // current multiplier bit is set, then shift the whole product right.
    // ---------------------------------------------------------------------
    always_comb begin
        // Signed multiply works on magnitudes; the most negative value has a
        // magnitude of 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
        a_mag = (op == OP_MULT && A[WIDTH-1]) ? (~A + WIDTH'(1)) : A;
        b_mag = (op == OP_MULT && B[WIDTH-1]) ? (~B + WIDTH'(1)) : B;

        step_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_step  = {step_sum, prod[WIDTH-1:1]};
        prod_final = neg ? (~prod_step + (2*WIDTH)'(1)) : prod_step;
    end

    // ---------------------------------------------------------------------
    // Control FSM and registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: state and outputs use non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
            illegal   <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            mcand     <= '0;
            prod      <= '0;
            neg       <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    out_valid <= 1'b0;
                    if (accept) begin
                        if (is_mul && HAS_MUL) begin
                            state <= S_MUL;
                            busy  <= 1'b1;
                            mcand <= a_mag;
                            prod  <= {{WIDTH{1'b0}}, b_mag};
                            neg   <= (op == OP_MULT) && (A[WIDTH-1] ^ B[WIDTH-1]);
                            cnt   <= '0;
                        end else begin
                            out_valid <= 1'b1;
                            result    <= alu_res;
                            zero      <= (alu_res == '0);
                            illegal   <= (op == OP_ILL);
                        end
                    end
                end

                S_MUL: begin
                    prod <= prod_step;
                    cnt  <= cnt + SHW'(1);
                    if (cnt == SHW'(WIDTH - 1)) begin
                        // Final step: commit the sign-corrected product and
                        // present lo as the result during DONE.
                        state     <= S_DONE;
                        hi_q      <= prod_final[2*WIDTH-1:WIDTH];
                        lo_q      <= prod_final[WIDTH-1:0];
                        result    <= prod_final[WIDTH-1:0];
                        zero      <= (prod_final[WIDTH-1:0] == '0);
                        illegal   <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end

                S_DONE: begin
                    // busy is still high at this edge, so nothing is accepted.
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end

                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// ---------------------------------------------------------------------------
// tb_alu_mc: directed, table-driven bench for alu_mc (WIDTH=32), plus
// hand-written sequences for multiply latency, busy handling and reset abort.
// ---------------------------------------------------------------------------
module tb_alu_mc;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [1:0]       aluop;
    logic [5:0]       funct;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             out_valid;
    logic             illegal;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int checks = 0;
    int errors = 0;

    alu_mc #(.WIDTH(WIDTH), .SHW(SHW), .MUL_EN(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .ALUOp     (aluop),
        .Funct     (funct),
        .Shamt     (shamt),
        .A         (a),
        .B         (b),
        .result    (result),
        .zero      (zero),
        .out_valid (out_valid),
        .illegal   (illegal),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  aluop;
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        ill;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One single-cycle op: drive for one cycle, check the pulse one cycle later.
    task automatic apply_op(input string name, input logic [1:0] op, input logic [5:0] fn,
                            input logic [4:0] sh, input logic [31:0] va, input logic [31:0] vb,
                            input logic [31:0] exp_res, input logic exp_zero, input logic exp_ill);
        @(negedge clk);
        in_valid = 1'b1; aluop = op; funct = fn; shamt = sh; a = va; b = vb;
        @(negedge clk);
        in_valid = 1'b0;
        check({name, "_valid"},   64'(out_valid), 64'(1'b1));
        check({name, "_result"},  64'(result),    64'(exp_res));
        check({name, "_zero"},    64'(zero),      64'(exp_zero));
        check({name, "_illegal"}, 64'(illegal),   64'(exp_ill));
    endtask

    // Multiply: count busy cycles and out_valid pulses after the accept edge.
    // With hold_add, an add (2+3) stays presented throughout and must be
    // accepted exactly once, on the first edge after DONE.
    task automatic do_mult(input string name, input logic [5:0] fn,
                           input logic [31:0] va, input logic [31:0] vb,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                           input bit hold_add);
        int busy_cnt = 0;
        int ov_cnt   = 0;
        int ov1_cyc  = 0;
        int ov2_cyc  = 0;
        logic [31:0] ov1_res = '0;
        logic [31:0] ov2_res = '0;
        logic        ov1_zero = 1'b0;
        logic        ov1_ill  = 1'b1;
        bit          left_busy = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; aluop = 2'b10; funct = fn; shamt = '0; a = va; b = vb;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (hold_add) begin
                    aluop = 2'b00; a = 32'd2; b = 32'd3;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (busy) busy_cnt++;
            else if (!left_busy && busy_cnt > 0) left_busy = 1'b1;
            if (out_valid) begin
                ov_cnt++;
                if (ov_cnt == 1) begin
                    ov1_cyc = k; ov1_res = result; ov1_zero = zero; ov1_ill = illegal;
                end else if (ov_cnt == 2) begin
                    ov2_cyc = k; ov2_res = result;
                    in_valid = 1'b0;
                end
            end
            if (!hold_add && left_busy) break;
            if (hold_add && k >= 40) break;
        end
        in_valid = 1'b0;
        check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(WIDTH + 1));
        check({name, "_valid_cycle"}, 64'(ov1_cyc),  64'(WIDTH + 1));
        check({name, "_result"},      64'(ov1_res),  64'(exp_lo));
        check({name, "_zero"},        64'(ov1_zero), 64'(exp_lo == 32'd0));
        check({name, "_illegal"},     64'(ov1_ill),  64'(1'b0));
        check({name, "_hi"},          64'(hi),       64'(exp_hi));
        check({name, "_lo"},          64'(lo),       64'(exp_lo));
        if (hold_add) begin
            check({name, "_pulses"},      64'(ov_cnt),  64'(2));
            check({name, "_add_cycle"},   64'(ov2_cyc), 64'(WIDTH + 3));
            check({name, "_add_result"},  64'(ov2_res), 64'(32'd5));
        end else begin
            check({name, "_pulses"},      64'(ov_cnt),  64'(1));
        end
    endtask

    initial begin
        int ov_seen;

        vecs[0]  = '{2'b10, 6'd32, 5'd0,  32'd7,        32'd5,        32'd12,       1'b0, 1'b0};
        vecs[1]  = '{2'b10, 6'd42, 5'd0,  32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0};
        vecs[2]  = '{2'b10, 6'd34, 5'd0,  32'd9,        32'd9,        32'd0,        1'b1, 1'b0};
        vecs[3]  = '{2'b10, 6'd0,  5'd31, 32'd0,        32'd1,        32'h80000000, 1'b0, 1'b0};
        vecs[4]  = '{2'b10, 6'd2,  5'd31, 32'd0,        32'h80000000, 32'd1,        1'b0, 1'b0};
        vecs[5]  = '{2'b10, 6'd36, 5'd0,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0};
        vecs[6]  = '{2'b10, 6'd37, 5'd0,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0};
        vecs[7]  = '{2'b00, 6'd63, 5'd0,  32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0};
        vecs[8]  = '{2'b01, 6'd7,  5'd0,  32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[9]  = '{2'b11, 6'd32, 5'd0,  32'd7,        32'd5,        32'd0,        1'b1, 1'b1};
        vecs[10] = '{2'b10, 6'd7,  5'd0,  32'd7,        32'd5,        32'd0,        1'b1, 1'b1};
        vecs[11] = '{2'b10, 6'd0,  5'd0,  32'd0,        32'h00001234, 32'h00001234, 1'b0, 1'b0};
        vecs[12] = '{2'b10, 6'd42, 5'd0,  32'd1,        32'hFFFFFFFF, 32'd0,        1'b1, 1'b0};
        vecs[13] = '{2'b10, 6'd2,  5'd4,  32'd0,        32'hFFFFFFFF, 32'h0FFFFFFF, 1'b0, 1'b0};
        vecs[14] = '{2'b10, 6'd16, 5'd0,  32'd0,        32'd0,        32'd0,        1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; aluop = '0; funct = '0; shamt = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_result",    64'(result),    64'(0));
        check("reset_zero",      64'(zero),      64'(0));
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_illegal",   64'(illegal),   64'(0));
        check("reset_busy",      64'(busy),      64'(0));
        check("reset_hi",        64'(hi),        64'(0));
        check("reset_lo",        64'(lo),        64'(0));

        for (int i = 0; i < 15; i++) begin
            apply_op($sformatf("vec%0d", i), vecs[i].aluop, vecs[i].funct, vecs[i].shamt,
                     vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].zero, vecs[i].ill);
        end
        @(negedge clk);
        check("pulse_drops", 64'(out_valid), 64'(0));

        // Signed multiply, then read HI/LO straight after.
        do_mult("mult_neg", 6'd24, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        apply_op("mfhi", 2'b10, 6'd16, 5'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
        apply_op("mflo", 2'b10, 6'd18, 5'd0, 32'd0, 32'd0, 32'hFFFFFFEB, 1'b0, 1'b0);

        // Most-negative squared: 2^62, lo == 0 so zero must be set.
        do_mult("mult_min", 6'd24, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);

        // Unsigned max squared with an add held on in_valid throughout busy.
        do_mult("multu_hold", 6'd25, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1);

        // Reset in the middle of a multiply (counter at 10 in cycle 11).
        @(negedge clk);
        in_valid = 1'b1; aluop = 2'b10; funct = 6'd24; a = 32'd5; b = 32'd6;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_busy_before", 64'(busy), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy",      64'(busy),      64'(0));
        check("abort_hi",        64'(hi),        64'(0));
        check("abort_lo",        64'(lo),        64'(0));
        check("abort_out_valid", 64'(out_valid), 64'(0));
        ov_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid || busy) ov_seen++;
        end
        check("abort_no_spurious", 64'(ov_seen), 64'(0));
        apply_op("post_abort_add", 2'b00, 6'd0, 5'd0, 32'd100, 32'd23, 32'd123, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, registered successor to the combinational ALU-control decoder.
- Merges ALUOp/Funct decode with the datapath, adds logical right shift, HI/LO registers and an iterative signed/unsigned multiplier.
- Sits in the EX stage.
- Multi-cycle ops raise `busy`, which the hazard unit uses to stall IF/ID/EX.

Parameters:
- WIDTH, 32, operand/result width in bits (even, ≥ 4).
- SHW, 5, shift-amount width; must equal clog2(WIDTH).
- MUL_EN, 1, 1 = multiplier/HI/LO present; 0 = mult/multu/mfhi/mflo decode as illegal.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation presented this cycle.
- ALUOp  in  2  00 add, 01 sub, 10 decode Funct, 11 reserved.
- Funct  in  6  R-type function field.
- Shamt  in  SHW  shift amount.
- A  in  WIDTH  operand rs.
- B  in  WIDTH  operand rt/immediate.
- result  out  WIDTH  registered result.
- zero  out  1  registered (result == 0).
- out_valid  out  1  one-cycle pulse: result/zero/illegal valid.
- illegal  out  1  undecodable op, qualified by out_valid.
- busy  out  1  block cannot accept; stall request.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: all outputs 0 (result, zero, out_valid, illegal, busy, hi, lo); FSM → IDLE; step counter 0. Applies in any state; a multiply in progress is aborted and HI/LO cleared.
- Accept rule: operation accepted on a rising edge when in_valid=1 and busy=0. in_valid while busy=1 is ignored; upstream holds the op via stall.
- Decode, ALUOp=10, by Funct:
  - 32 add, 34 sub, 36 and, 37 or: as named.
  - 42 slt: signed A<B → 1, else 0.
  - 0 sll: B<<Shamt.
  - 2 srl: B>>Shamt, logical.
  - 16 mfhi → hi; 18 mflo → lo.
  - 24 mult: signed; 25 multu: unsigned.
- Decode, other ALUOp: 00 → add; 01 → sub; 11 → illegal. Any other Funct is illegal.
- Add/sub: modulo 2^WIDTH, no overflow trap.
- Single-cycle ops (all except mult/multu): result/zero/illegal/out_valid registered at the accepting edge, so latency is 1 cycle. out_valid is high for exactly the following cycle unless another op is accepted.
- Illegal op: result=0, zero=1, illegal=1, out_valid=1; HI/LO unchanged.
- FSM states: IDLE, MUL, DONE. busy = (state != IDLE).
  - IDLE --accept mult/multu--> MUL. Latch |A|,|B| (signed) or A,B (multu) and the sign flag; counter=0; out_valid=0 next cycle.
  - MUL: one shift-add step per edge over the 2·WIDTH product. When counter==WIDTH-1, go to DONE; the final product is sign-corrected (two's-complement negate if sign flag) and written to {hi,lo} on that edge.
  - DONE: out_valid=1, result=lo, zero=(lo==0), illegal=0; no accept. Next edge → IDLE.
- Mult latency: accept edge to out_valid cycle = WIDTH+1 cycles; busy high WIDTH+1 cycles. A new op may be accepted on the edge leaving DONE only if busy=0 at that edge, so first acceptance is the edge after DONE.
- mfhi/mflo issued back-to-back after a mult read the updated HI/LO; no interlock needed because busy blocks issue.
- Shamt ≥ WIDTH is impossible by width; Shamt=0 passes B through.
- MUL_EN=0: no HI/LO flops (hi/lo tied 0); FSM never leaves IDLE.

Test Plan:
- Reset then ALUOp=10, Funct=32, A=7, B=5, in_valid 1 cycle → next cycle out_valid=1, result=12, zero=0, illegal=0.
- Funct=42, A=0xFFFFFFFF, B=1 → result=1. Funct=34, A=B=9 → result=0, zero=1.
- Funct=0, B=1, Shamt=31 → 0x80000000. Funct=2, B=0x80000000, Shamt=31 → 1.
- Funct=24, A=-3, B=7 → busy high 33 cycles, out_valid on cycle 33, lo=0xFFFFFFEB, hi=0xFFFFFFFF. Then mfhi → 0xFFFFFFFF.
- Funct=25, A=B=0xFFFFFFFF → hi=0xFFFFFFFE, lo=1. in_valid held with add during busy → ignored until IDLE, then result produced once.
- ALUOp=11 → illegal=1, result=0. rst asserted mid-mult at step 10 → next cycle busy=0, hi=lo=0, out_valid=0, no spurious out_valid.
